inst_fetch_queue: RTL and testbench

//  Decoupling queue between PC generation / instruction ROM and the IF/ID decode stage.

---
 rtl/inst_fetch_queue_pkg.sv | 23 ++
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fq_mem.sv | 26 ++
 rtl/inst_fetch_queue.sv | 83 ++++++++
 tb/tb_inst_fetch_queue.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-path definitions: reset level, bus widths and queue occupancy operations.
// Reused by pc_reg, decode and the fetch queue.
package inst_fetch_queue_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam int          INST_ADDR_BUS = 32;
  localparam int          INST_BUS      = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam int          FQ_DEPTH      = 4;

  // Occupancy change for one cycle, encoded as {push, pop}
  typedef enum logic [1:0] {
    OCC_IDLE = 2'b00,
    OCC_POP  = 2'b01,
    OCC_PUSH = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_e;

  function automatic occ_op_e occ_op(input logic push, input logic pop);
    return occ_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode handshake bundle around the instruction fetch queue.
// master = fetch source and decode sink; slave = the queue itself.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [ADDR_W-1:0]        in_pc_i;
  logic [DATA_W-1:0]        in_inst_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [ADDR_W-1:0]        out_pc_o;
  logic [DATA_W-1:0]        out_inst_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_inst_o, count_o
  );

  modport slave (
    input  in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_inst_o, count_o
  );
endinterface

// File: rtl/inst_fq_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
// Not reset; stale contents are masked by the occupancy count in the parent.
module inst_fq_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order {pc, inst} queue decoupling instruction fetch from decode.
// Valid/ready on both sides; flush drops every queued entry in one cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int DATA_W = INST_BUS,
  parameter int DEPTH  = FQ_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  inst_fetch_queue_if.slave  fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [ENT_W-1:0]  rdata_s;
  logic [ADDR_W-1:0] head_pc_s;
  logic [DATA_W-1:0] head_inst_s;

  inst_fq_mem #(.DEPTH(DEPTH), .W(ENT_W)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({fq.in_pc_i, fq.in_inst_i}),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Handshake qualification and head masking; a full queue refuses input even when popping
  always_comb begin
    in_ready_s  = (count_r < FULL_CNT);
    out_valid_s = (count_r != {CNT_W{1'b0}});
    push_s      = fq.in_valid_i & in_ready_s;
    pop_s       = out_valid_s & fq.out_ready_i;
    if (out_valid_s) begin
      head_pc_s   = rdata_s[ENT_W-1:DATA_W];
      head_inst_s = rdata_s[DATA_W-1:0];
    end else begin
      head_pc_s   = {ADDR_W{1'b0}};
      head_inst_s = {DATA_W{1'b0}};
    end
  end

  assign fq.in_ready_o  = in_ready_s;
  assign fq.out_valid_o = out_valid_s;
  assign fq.out_pc_o    = head_pc_s;
  assign fq.out_inst_o  = head_inst_s;
  assign fq.count_o     = count_r;

  // Pointers and occupancy; reset and flush both empty the queue and win over push/pop
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case (occ_op(push_s, pop_s))
        OCC_PUSH: count_r <= count_r + CNT_W'(1);
        OCC_POP:  count_r <= count_r - CNT_W'(1);
        default:  count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH = 4).
module tb_inst_fetch_queue;

  logic clk;
  logic rst;
  logic flush;
  int   total;
  int   bad;

  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) fq_bus ();

  inst_fetch_queue dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .fq      (fq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc);
    fq_bus.in_valid_i = v;
    fq_bus.in_pc_i    = pc;
    fq_bus.in_inst_i  = inst_of(pc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    flush = 1'b0;
    drive_in(1'b0, 32'h0);
    fq_bus.out_ready_i = 1'b0;

    // 1: reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 64'(fq_bus.count_o), 64'd0);
    chk("rst_valid", 64'(fq_bus.out_valid_o), 64'd0);
    chk("rst_ready", 64'(fq_bus.in_ready_o), 64'd1);
    chk("rst_inst", 64'(fq_bus.out_inst_o), 64'd0);
    chk("rst_pc", 64'(fq_bus.out_pc_o), 64'd0);

    // 2: fill, refuse fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 32'(i * 4));
      tick();
    end
    chk("fill_count", 64'(fq_bus.count_o), 64'd4);
    chk("fill_ready", 64'(fq_bus.in_ready_o), 64'd0);
    drive_in(1'b1, 32'h10);
    tick();
    chk("fifth_refused", 64'(fq_bus.count_o), 64'd4);
    drive_in(1'b0, 32'h0);
    fq_bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(fq_bus.out_pc_o), 64'(i * 4));
      chk("drain_inst", 64'(fq_bus.out_inst_o), 64'(inst_of(32'(i * 4))));
      tick();
    end
    chk("drain_valid", 64'(fq_bus.out_valid_o), 64'd0);
    chk("drain_count", 64'(fq_bus.count_o), 64'd0);
    chk("drain_pc_zero", 64'(fq_bus.out_pc_o), 64'd0);

    // 3: steady stream at count 1
    fq_bus.out_ready_i = 1'b0;
    drive_in(1'b1, 32'h100);
    tick();
    fq_bus.out_ready_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      drive_in(1'b1, 32'(32'h100 + 4 * k));
      tick();
      chk("stream_count", 64'(fq_bus.count_o), 64'd1);
      chk("stream_pc", 64'(fq_bus.out_pc_o), 64'(32'h100 + 4 * k));
    end
    drive_in(1'b0, 32'h0);
    tick();
    chk("stream_empty", 64'(fq_bus.count_o), 64'd0);

    // 4: flush with concurrent push and pop
    fq_bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 32'(32'h200 + 4 * i));
      tick();
    end
    chk("pre_flush_count", 64'(fq_bus.count_o), 64'd3);
    flush = 1'b1;
    drive_in(1'b1, 32'h20C);
    fq_bus.out_ready_i = 1'b1;
    tick();
    flush = 1'b0;
    drive_in(1'b0, 32'h0);
    fq_bus.out_ready_i = 1'b0;
    chk("flush_count", 64'(fq_bus.count_o), 64'd0);
    chk("flush_valid", 64'(fq_bus.out_valid_o), 64'd0);
    chk("flush_pc", 64'(fq_bus.out_pc_o), 64'd0);
    tick();
    chk("flush_no_entry", 64'(fq_bus.count_o), 64'd0);

    // 5: full queue with simultaneous push request and pop
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 32'(32'h300 + 4 * i));
      tick();
    end
    chk("full_count", 64'(fq_bus.count_o), 64'd4);
    drive_in(1'b1, 32'h310);
    fq_bus.out_ready_i = 1'b1;
    tick();
    chk("full_pop_only", 64'(fq_bus.count_o), 64'd3);
    chk("full_head", 64'(fq_bus.out_pc_o), 64'h304);
    fq_bus.out_ready_i = 1'b0;
    tick();
    chk("held_accept", 64'(fq_bus.count_o), 64'd4);
    drive_in(1'b0, 32'h0);
    fq_bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain_pc", 64'(fq_bus.out_pc_o), 64'(32'h304 + 4 * i));
      tick();
    end
    chk("full_drain_empty", 64'(fq_bus.count_o), 64'd0);

    // 6: reset mid-stream
    fq_bus.out_ready_i = 1'b0;
    drive_in(1'b1, 32'h400);
    tick();
    drive_in(1'b1, 32'h404);
    tick();
    chk("pre_rst_count", 64'(fq_bus.count_o), 64'd2);
    rst = 1'b1;
    drive_in(1'b1, 32'h408);
    tick();
    rst = 1'b0;
    drive_in(1'b0, 32'h0);
    chk("mrst_count", 64'(fq_bus.count_o), 64'd0);
    chk("mrst_valid", 64'(fq_bus.out_valid_o), 64'd0);
    chk("mrst_ready", 64'(fq_bus.in_ready_o), 64'd1);
    chk("mrst_pc", 64'(fq_bus.out_pc_o), 64'd0);
    chk("mrst_inst", 64'(fq_bus.out_inst_o), 64'd0);
    drive_in(1'b1, 32'h40);
    tick();
    drive_in(1'b0, 32'h0);
    chk("post_rst_count", 64'(fq_bus.count_o), 64'd1);
    chk("post_rst_pc", 64'(fq_bus.out_pc_o), 64'h40);
    chk("post_rst_inst", 64'(fq_bus.out_inst_o), 64'(inst_of(32'h40)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
